// File: rtl/huffman_pkg.sv
// Shared Huffman code table, widths and FSM encoding for the encoder/decoder pair.
package huffman_pkg;

  localparam int MAX_LEN = 6;
  localparam int SYM_W   = 4;
  localparam int NUM_SYM = 10;

  // Codes are right-aligned; LEN gives how many low bits are significant.
  localparam logic [MAX_LEN-1:0] CODE [NUM_SYM] = '{
    6'b111111, 6'b000000, 6'b000101, 6'b001101, 6'b000100,
    6'b001100, 6'b011110, 6'b001110, 6'b111110, 6'b000001
  };
  localparam logic [2:0] LEN [NUM_SYM] = '{
    3'd6, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd5, 3'd4, 3'd6, 3'd2
  };

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_HUNT_ENC = 2'd1;
  localparam logic [1:0] ST_ACC_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_HUNT = ST_HUNT_ENC,
    ST_ACC  = ST_ACC_ENC
  } state_t;

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [2:0] len);
    len_mask = (6'd1 << len) - 6'd1;
  endfunction

endpackage

// File: rtl/huffman_code_match.sv
// Combinational lookup of a right-aligned partial codeword against the shared table.
module huffman_code_match
  import huffman_pkg::*;
(
  input  logic [5:0] sreg,
  input  logic [2:0] len,
  output logic       hit,
  output logic [3:0] sym
);

  // Scan every table entry; the prefix property guarantees at most one hit.
  always_comb begin
    hit = 1'b0;
    sym = 4'd0;
    for (int i = 0; i < NUM_SYM; i++) begin
      if ((len == LEN[i]) && ((sreg & len_mask(len)) == CODE[i])) begin
        hit = 1'b1;
        sym = 4'(i);
      end else begin
        hit = hit;
        sym = sym;
      end
    end
  end

endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: rebuilds 4-bit symbols from a strobed, MSB-first code bitstream.
module huffman_decoder
  import huffman_pkg::*;
#(
  parameter int GAP_MAX = 16,
  parameter int CNT_W   = 16
) (
  input  logic             Clk_in,
  input  logic             n_Rst,
  input  logic             Start,
  input  logic             Bit_in,
  input  logic             Bit_valid,
  output logic [3:0]       Data_out,
  output logic             Data_valid,
  output logic             Busy,
  output logic             Err,
  output logic [CNT_W-1:0] Sym_count
);

  localparam int GAP_W = $clog2(GAP_MAX + 1);

  state_t             state_r, state_nxt_s;
  logic [5:0]         sreg_r, sreg_nxt_s, cand_sreg_s;
  logic [2:0]         len_r, len_nxt_s, cand_len_s;
  logic [GAP_W-1:0]   gap_r, gap_nxt_s;
  logic               load_sym_s, timeout_s, hit_s;
  logic [3:0]         sym_s;
  logic [3:0]         data_out_r;
  logic               data_valid_r, busy_r, err_r;
  logic [CNT_W-1:0]   sym_count_r;

  // Matching looks at the codeword including the bit arriving this cycle.
  assign cand_sreg_s = {sreg_r[4:0], Bit_in};
  assign cand_len_s  = len_r + 3'd1;

  huffman_code_match u_match (
    .sreg (cand_sreg_s),
    .len  (cand_len_s),
    .hit  (hit_s),
    .sym  (sym_s)
  );

  // Next-state and datapath control.
  always_comb begin
    state_nxt_s = state_r;
    sreg_nxt_s  = sreg_r;
    len_nxt_s   = len_r;
    gap_nxt_s   = gap_r;
    load_sym_s  = 1'b0;
    timeout_s   = 1'b0;
    if (Start) begin
      state_nxt_s = ST_HUNT;
      len_nxt_s   = 3'd0;
      gap_nxt_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_HUNT: begin
          if (Bit_valid) begin
            sreg_nxt_s  = cand_sreg_s;
            len_nxt_s   = 3'd1;
            gap_nxt_s   = '0;
            state_nxt_s = ST_ACC;
          end else begin
            state_nxt_s = ST_HUNT;
          end
        end
        ST_ACC: begin
          if (Bit_valid) begin
            sreg_nxt_s = cand_sreg_s;
            gap_nxt_s  = '0;
            if (hit_s) begin
              load_sym_s  = 1'b1;
              len_nxt_s   = 3'd0;
              state_nxt_s = ST_HUNT;
            end else begin
              len_nxt_s = cand_len_s;
            end
          end else if (gap_r == GAP_W'(GAP_MAX - 1)) begin
            timeout_s   = 1'b1;
            len_nxt_s   = 3'd0;
            gap_nxt_s   = '0;
            state_nxt_s = ST_HUNT;
          end else begin
            gap_nxt_s = gap_r + GAP_W'(1);
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          len_nxt_s   = 3'd0;
          gap_nxt_s   = '0;
        end
      endcase
    end
  end

  // FSM state, shift register and gap counter.
  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      state_r <= ST_IDLE;
      sreg_r  <= 6'd0;
      len_r   <= 3'd0;
      gap_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      sreg_r  <= sreg_nxt_s;
      len_r   <= len_nxt_s;
      gap_r   <= gap_nxt_s;
    end
  end

  // Registered outputs and the sticky error / symbol counter.
  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      data_out_r   <= 4'hF;
      data_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
      sym_count_r  <= '0;
    end else begin
      data_valid_r <= load_sym_s;
      busy_r       <= (state_nxt_s == ST_ACC);
      if (load_sym_s) begin
        data_out_r <= sym_s;
      end
      if (Start) begin
        err_r       <= 1'b0;
        sym_count_r <= '0;
      end else begin
        if (timeout_s) begin
          err_r <= 1'b1;
        end
        if (load_sym_s) begin
          sym_count_r <= sym_count_r + CNT_W'(1);
        end
      end
    end
  end

  assign Data_out   = data_out_r;
  assign Data_valid = data_valid_r;
  assign Busy       = busy_r;
  assign Err        = err_r;
  assign Sym_count  = sym_count_r;

endmodule
